// File: rtl/periph_obi_reg_bridge.sv
`default_nettype none
// ============================================================================
// periph_obi_reg_bridge
//   OBI slave to NumPorts register-interface peripherals: request FIFO,
//   address decode, one access in flight, unmapped and timeout errors.
// Revision: 1.0
// ============================================================================
module periph_obi_reg_bridge #(
    parameter int unsigned NumPorts      = 8,
    parameter int unsigned FifoDepth     = 2,
    parameter int unsigned TimeoutCycles = 256,
    parameter logic [NumPorts-1:0][31:0] PortBase = '0,
    parameter logic [NumPorts-1:0][31:0] PortEnd  = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   obi_req_i,
    output logic                   obi_gnt_o,
    input  logic [31:0]            obi_addr_i,
    input  logic                   obi_we_i,
    input  logic [3:0]             obi_be_i,
    input  logic [31:0]            obi_wdata_i,
    output logic                   obi_rvalid_o,
    output logic [31:0]            obi_rdata_o,
    output logic                   obi_err_o,
    output logic [NumPorts-1:0]    reg_valid_o,
    output logic                   reg_write_o,
    output logic [31:0]            reg_addr_o,
    output logic [31:0]            reg_wdata_o,
    output logic [3:0]             reg_wstrb_o,
    input  logic [NumPorts-1:0]    reg_ready_i,
    input  logic [NumPorts*32-1:0] reg_rdata_i,
    input  logic [NumPorts-1:0]    reg_error_i,
    output logic                   timeout_o
);

    localparam int unsigned PTR_W = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CNT_W = $clog2(FifoDepth + 1);
    localparam int unsigned IDX_W = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(FifoDepth - 1);
    localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FifoDepth);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [15:0]      TIMEOUT_LAST = 16'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [68:0]       fifo_mem_q [FifoDepth];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              write_q, write_d, err_q, err_d, timeout_q, timeout_d;
    logic [15:0]       wait_q, wait_d;

    logic              push, pop, hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [68:0]       head;
    logic [31:0]       port_rdata [NumPorts];

    for (genvar g = 0; g < NumPorts; g++) begin : g_port_rdata
        assign port_rdata[g] = reg_rdata_i[32*g +: 32];
    end

    assign obi_gnt_o = (count_q != CNT_FULL);
    assign push      = obi_req_i && obi_gnt_o;
    assign pop       = (state_q == RESP);
    assign head      = fifo_mem_q[rd_ptr_q];

    // Descending scan so the lowest matching port is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int p = NumPorts - 1; p >= 0; p--) begin
            if ((head[68:37] >= PortBase[p]) && (head[68:37] < PortEnd[p])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(p);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (!push && pop) count_d = count_q - CNT_ONE;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (hit) begin
                        idx_d   = hit_idx;
                        addr_d  = head[68:37];
                        write_d = head[36];
                        wstrb_d = head[35:32];
                        wdata_d = head[31:0];
                        wait_d  = '0;
                        state_d = ACCESS;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                // A ready arriving on the last allowed cycle beats the timeout.
                if (reg_ready_i[idx_q]) begin
                    rdata_d = write_q ? '0 : port_rdata[idx_q];
                    err_d   = reg_error_i[idx_q];
                    state_d = RESP;
                end else if (wait_q == TIMEOUT_LAST) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else if (wait_q != 16'hFFFF) begin
                    wait_d = wait_q + 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FifoDepth; i++) fifo_mem_q[i] <= '0;
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            wait_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (push) fifo_mem_q[wr_ptr_q] <= {obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i};
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        reg_valid_o = '0;
        if (state_q == ACCESS) reg_valid_o[idx_q] = 1'b1;
    end

    assign reg_write_o  = write_q;
    assign reg_addr_o   = addr_q;
    assign reg_wdata_o  = wdata_q;
    assign reg_wstrb_o  = wstrb_q;
    assign obi_rvalid_o = (state_q == RESP);
    assign obi_rdata_o  = obi_rvalid_o ? rdata_q : '0;
    assign obi_err_o    = obi_rvalid_o ? err_q : 1'b0;
    assign timeout_o    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_periph_obi_reg_bridge.sv
`default_nettype none
// ============================================================================
// tb_periph_obi_reg_bridge
//   Directed and randomized checks of the bridge against a transaction model.
// Revision: 1.0
// ============================================================================
module tb_periph_obi_reg_bridge;

    localparam int NP      = 4;
    localparam int TIMEOUT = 4;
    localparam logic [31:0] BASE  [NP] = '{32'h0000_0100, 32'h0000_0000, 32'h0000_2000, 32'h0000_4000};
    localparam logic [31:0] LIMIT [NP] = '{32'h0000_0200, 32'h0000_1000, 32'h0000_3000, 32'h0000_5000};

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           req = 1'b0, gnt, we = 1'b0, rvalid, rerr, rwrite, timeout;
    logic [31:0]    addr = '0, wdata = '0, rdata, raddr, rwdata;
    logic [3:0]     be = '0, rwstrb;
    logic [NP-1:0]  rvalid_port, ready, perr;
    logic [NP*32-1:0] rdata_bus;

    int          wait_cfg [NP];
    bit          never    [NP];
    bit          err_cfg  [NP];
    logic [31:0] rd_base  [NP];
    int          wcnt     [NP];

    logic [31:0] rsp_d_q [$];
    logic        rsp_e_q [$];
    acc_t        acc_q   [$];
    int          str_cnt [NP];
    int          to_cnt, qual_viol, onehot_viol;
    int          n_checks, n_fail;

    periph_obi_reg_bridge #(
        .NumPorts      (NP),
        .FifoDepth     (2),
        .TimeoutCycles (TIMEOUT),
        .PortBase      ({32'h0000_4000, 32'h0000_2000, 32'h0000_0000, 32'h0000_0100}),
        .PortEnd       ({32'h0000_5000, 32'h0000_3000, 32'h0000_1000, 32'h0000_0200})
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .obi_req_i    (req),
        .obi_gnt_o    (gnt),
        .obi_addr_i   (addr),
        .obi_we_i     (we),
        .obi_be_i     (be),
        .obi_wdata_i  (wdata),
        .obi_rvalid_o (rvalid),
        .obi_rdata_o  (rdata),
        .obi_err_o    (rerr),
        .reg_valid_o  (rvalid_port),
        .reg_write_o  (rwrite),
        .reg_addr_o   (raddr),
        .reg_wdata_o  (rwdata),
        .reg_wstrb_o  (rwstrb),
        .reg_ready_i  (ready),
        .reg_rdata_i  (rdata_bus),
        .reg_error_i  (perr),
        .timeout_o    (timeout)
    );

    // Peripheral models: ready after wait_cfg strobe cycles, data derived from address.
    always @(posedge clk) begin
        for (int p = 0; p < NP; p++) wcnt[p] <= rvalid_port[p] ? wcnt[p] + 1 : 0;
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            ready[p]             = !never[p] && (wcnt[p] >= wait_cfg[p]);
            perr[p]              = err_cfg[p];
            rdata_bus[32*p +: 32] = rd_base[p] ^ (raddr & 32'h0000_0FF0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid) begin
                rsp_d_q.push_back(rdata);
                rsp_e_q.push_back(rerr);
            end else if (rdata !== 32'h0 || rerr !== 1'b0) begin
                qual_viol++;
            end
            if (rvalid_port != '0) begin
                if ($countones(rvalid_port) != 1) onehot_viol++;
                for (int p = 0; p < NP; p++) begin
                    if (rvalid_port[p]) begin
                        str_cnt[p]++;
                        if (ready[p]) acc_q.push_back({2'(p), raddr, rwrite, rwstrb, rwdata});
                    end
                end
            end
            if (timeout) to_cnt++;
        end
    end

    function automatic int decode(input logic [31:0] a);
        for (int p = 0; p < NP; p++) if (a >= BASE[p] && a < LIMIT[p]) return p;
        return -1;
    endfunction

    task automatic clear_mon();
        rsp_d_q.delete();
        rsp_e_q.delete();
        acc_q.delete();
        for (int p = 0; p < NP; p++) str_cnt[p] = 0;
        to_cnt = 0;
    endtask

    task automatic cfg_port(input int p, input int w, input bit nv, input bit e, input logic [31:0] rb);
        wait_cfg[p] = w;
        never[p]    = nv;
        err_cfg[p]  = e;
        rd_base[p]  = rb;
    endtask

    // Called on a negedge; returns on the negedge after the handshake edge.
    task automatic send(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output int stalls);
        stalls = 0;
        req = 1'b1; addr = a; we = w; be = b; wdata = d;
        while (!gnt && stalls < 200) begin
            @(negedge clk);
            stalls++;
        end
        if (!gnt) begin
            n_checks++; n_fail++;
            $display("FAIL send_grant: gnt=%b after %0d cycles, expected 1", gnt, stalls);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int g = 0;
        while (rsp_d_q.size() < n && g < 300) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (rsp_d_q.size() != n) begin
            n_fail++;
            $display("FAIL rsp_count: got %0d responses, expected %0d", rsp_d_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rvalid_port !== 4'b0 || rvalid !== 1'b0) begin n_fail++;
            $display("FAIL reset_in_strobe: valid=%b rvalid=%b, expected 0", rvalid_port, rvalid); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL reset_gnt: got %b expected 1", gnt); end
        n_checks++; if ({rvalid, rerr, timeout} !== 3'b000 || rdata !== 32'h0) begin n_fail++;
            $display("FAIL reset_resp: rvalid=%b err=%b to=%b rdata=%h, expected zeros", rvalid, rerr, timeout, rdata); end
        n_checks++; if ({rwrite, rwstrb} !== 5'b0 || raddr !== 32'h0 || rwdata !== 32'h0 || rvalid_port !== 4'b0) begin
            n_fail++; $display("FAIL reset_reg_bus: w=%b strb=%h a=%h d=%h v=%b, expected zeros",
                               rwrite, rwstrb, raddr, rwdata, rvalid_port); end
    endtask

    task automatic test_zero_wait_read();
        int st;
        cfg_port(2, 0, 1'b0, 1'b0, 32'hA5A5_0001);
        clear_mon();
        send(32'h0000_2004, 1'b0, 4'hF, 32'h0, st);
        n_checks++; if (rvalid_port !== 4'b0000) begin n_fail++;
            $display("FAIL zw_strobe_t1: got %b expected 0000", rvalid_port); end
        @(negedge clk);
        n_checks++; if (rvalid_port !== 4'b0100) begin n_fail++;
            $display("FAIL zw_strobe_t2: got %b expected 0100", rvalid_port); end
        n_checks++; if (raddr !== 32'h0000_2004 || rwrite !== 1'b0) begin n_fail++;
            $display("FAIL zw_reg_fields: addr=%h write=%b expected 00002004/0", raddr, rwrite); end
        @(negedge clk);
        n_checks++; if (rvalid !== 1'b1 || rdata !== 32'hA5A5_0001 || rerr !== 1'b0) begin n_fail++;
            $display("FAIL zw_resp_t3: rvalid=%b rdata=%h err=%b expected 1/a5a50001/0", rvalid, rdata, rerr); end
        @(negedge clk);
        n_checks++; if (rvalid !== 1'b0) begin n_fail++;
            $display("FAIL zw_resp_single: rvalid=%b expected 0", rvalid); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unmapped();
        int st;
        clear_mon();
        send(32'hF000_0000, 1'b1, 4'hF, 32'h1234_5678, st);
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL um_early: rvalid=%b expected 0", rvalid); end
        @(negedge clk);
        n_checks++; if (rvalid !== 1'b1 || rerr !== 1'b1 || rdata !== 32'h0) begin n_fail++;
            $display("FAIL um_resp_t2: rvalid=%b err=%b rdata=%h expected 1/1/0", rvalid, rerr, rdata); end
        repeat (3) @(negedge clk);
        n_checks++; if (str_cnt[0] + str_cnt[1] + str_cnt[2] + str_cnt[3] != 0) begin n_fail++;
            $display("FAIL um_no_strobe: %0d strobe cycles, expected 0", str_cnt[0] + str_cnt[1] + str_cnt[2] + str_cnt[3]); end
    endtask

    task automatic test_timeout();
        int st;
        cfg_port(3, 0, 1'b1, 1'b0, 32'h0);
        cfg_port(2, 0, 1'b0, 1'b0, 32'h1111_2222);
        clear_mon();
        send(32'h0000_4000, 1'b0, 4'hF, 32'h0, st);
        send(32'h0000_2010, 1'b0, 4'hF, 32'h0, st);
        wait_rsp(2);
        n_checks++; if (str_cnt[3] != TIMEOUT) begin n_fail++;
            $display("FAIL to_strobe_len: got %0d cycles expected %0d", str_cnt[3], TIMEOUT); end
        n_checks++; if (to_cnt != 1) begin n_fail++; $display("FAIL to_pulse: got %0d pulses expected 1", to_cnt); end
        if (rsp_d_q.size() == 2) begin
            n_checks++; if (rsp_e_q[0] !== 1'b1 || rsp_d_q[0] !== 32'h0) begin n_fail++;
                $display("FAIL to_resp: err=%b rdata=%h expected 1/0", rsp_e_q[0], rsp_d_q[0]); end
            n_checks++; if (rsp_e_q[1] !== 1'b0 || rsp_d_q[1] !== (32'h1111_2222 ^ 32'h10)) begin n_fail++;
                $display("FAIL to_next_resp: err=%b rdata=%h expected 0/%h", rsp_e_q[1], rsp_d_q[1], 32'h1111_2222 ^ 32'h10); end
        end
        // Ready arrives on the very cycle the timeout would fire.
        cfg_port(3, TIMEOUT - 1, 1'b0, 1'b0, 32'h3333_0000);
        clear_mon();
        send(32'h0000_4020, 1'b0, 4'hF, 32'h0, st);
        wait_rsp(1);
        n_checks++; if (to_cnt != 0) begin n_fail++; $display("FAIL to_ready_wins_pulse: got %0d pulses expected 0", to_cnt); end
        if (rsp_d_q.size() == 1) begin
            n_checks++; if (rsp_e_q[0] !== 1'b0 || rsp_d_q[0] !== 32'h3333_0020) begin n_fail++;
                $display("FAIL to_ready_wins_resp: err=%b rdata=%h expected 0/33330020", rsp_e_q[0], rsp_d_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int st [4];
        logic [31:0] d [4];
        logic [3:0]  b [4];
        logic        g_after2;
        cfg_port(2, 3, 1'b0, 1'b0, 32'h0);
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            b[i] = 4'($urandom_range(1, 15));
        end
        send(32'h0000_2100, 1'b1, b[0], d[0], st[0]);
        send(32'h0000_2104, 1'b1, b[1], d[1], st[1]);
        g_after2 = gnt;
        send(32'h0000_2108, 1'b1, b[2], d[2], st[2]);
        send(32'h0000_210C, 1'b1, b[3], d[3], st[3]);
        wait_rsp(4);
        n_checks++; if (st[0] != 0 || st[1] != 0 || g_after2 !== 1'b0 || st[2] == 0) begin n_fail++;
            $display("FAIL bp_gnt: stalls %0d/%0d/%0d gnt_after2=%b expected 0/0/>0 and 0", st[0], st[1], st[2], g_after2); end
        n_checks++; if (acc_q.size() != 4) begin n_fail++;
            $display("FAIL bp_access_count: got %0d expected 4", acc_q.size()); end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            n_checks++;
            if (acc_q[i] !== {2'd2, 32'h0000_2100 + 32'(4 * i), 1'b1, b[i], d[i]}) begin n_fail++;
                $display("FAIL bp_access_%0d: got %h expected %h", i, acc_q[i],
                         {2'd2, 32'h0000_2100 + 32'(4 * i), 1'b1, b[i], d[i]}); end
        end
        for (int i = 0; i < 4 && i < rsp_d_q.size(); i++) begin
            n_checks++;
            if (rsp_e_q[i] !== 1'b0 || rsp_d_q[i] !== 32'h0) begin n_fail++;
                $display("FAIL bp_resp_%0d: err=%b rdata=%h expected 0/0", i, rsp_e_q[i], rsp_d_q[i]); end
        end
    endtask

    task automatic test_overlap_error();
        int st;
        cfg_port(0, 1, 1'b0, 1'b1, 32'h0BAD_0000);
        cfg_port(1, 0, 1'b0, 1'b0, 32'h7777_7777);
        clear_mon();
        send(32'h0000_0100, 1'b0, 4'hF, 32'h0, st);
        wait_rsp(1);
        n_checks++; if (str_cnt[0] != 2 || str_cnt[1] != 0) begin n_fail++;
            $display("FAIL ov_strobe: port0=%0d port1=%0d cycles expected 2/0", str_cnt[0], str_cnt[1]); end
        if (rsp_d_q.size() == 1) begin
            n_checks++; if (rsp_e_q[0] !== 1'b1 || rsp_d_q[0] !== 32'h0BAD_0100) begin n_fail++;
                $display("FAIL ov_resp: err=%b rdata=%h expected 1/0bad0100", rsp_e_q[0], rsp_d_q[0]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp_d [$];
        logic        w, exp_e [$];
        logic [3:0]  b;
        acc_t        exp_a [$];
        int          p, st, n_to;
        for (int i = 0; i < NP; i++) cfg_port(i, $urandom_range(0, 5), 1'b0, 1'($urandom_range(0, 1)), $urandom);
        clear_mon();
        n_to = 0;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h100 + $urandom_range(0, 63) * 4;
                1:       a = $urandom_range(0, 1023) * 4;
                2:       a = 32'h2000 + $urandom_range(0, 1023) * 4;
                3:       a = 32'h4000 + $urandom_range(0, 1023) * 4;
                default: a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
            endcase
            w = 1'($urandom_range(0, 1));
            b = 4'($urandom);
            d = $urandom;
            p = decode(a);
            if (p < 0 || wait_cfg[p] >= TIMEOUT) begin
                exp_d.push_back(32'h0);
                exp_e.push_back(1'b1);
                if (p >= 0) n_to++;
            end else begin
                exp_d.push_back(w ? 32'h0 : rd_base[p] ^ (a & 32'h0000_0FF0));
                exp_e.push_back(err_cfg[p]);
                exp_a.push_back({2'(p), a, w, b, d});
            end
            send(a, w, b, d, st);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_rsp(30);
        for (int i = 0; i < 30 && i < rsp_d_q.size(); i++) begin
            n_checks++;
            if (rsp_d_q[i] !== exp_d[i] || rsp_e_q[i] !== exp_e[i]) begin n_fail++;
                $display("FAIL rnd_resp_%0d: rdata=%h err=%b expected %h/%b", i, rsp_d_q[i], rsp_e_q[i], exp_d[i], exp_e[i]); end
        end
        n_checks++; if (acc_q.size() != exp_a.size()) begin n_fail++;
            $display("FAIL rnd_access_count: got %0d expected %0d", acc_q.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < acc_q.size(); i++) begin
            n_checks++;
            if (acc_q[i] !== exp_a[i]) begin n_fail++;
                $display("FAIL rnd_access_%0d: got %h expected %h", i, acc_q[i], exp_a[i]); end
        end
        n_checks++; if (to_cnt != n_to) begin n_fail++;
            $display("FAIL rnd_timeouts: got %0d expected %0d", to_cnt, n_to); end
    endtask

    task automatic test_reset_mid();
        int st;
        cfg_port(3, 0, 1'b1, 1'b0, 32'h0);
        cfg_port(2, 0, 1'b0, 1'b0, 32'h0);
        clear_mon();
        send(32'h0000_4000, 1'b0, 4'hF, 32'h0, st);
        send(32'h0000_2000, 1'b0, 4'hF, 32'h0, st);
        n_checks++; if (rvalid_port !== 4'b1000) begin n_fail++;
            $display("FAIL rm_in_access: strobe=%b expected 1000", rvalid_port); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rvalid_port !== 4'b0000) begin n_fail++;
            $display("FAIL rm_async_drop: strobe=%b expected 0000", rvalid_port); end
        @(negedge clk);
        rst_n = 1'b1;
        never[3] = 1'b0;
        clear_mon();
        repeat (12) @(negedge clk);
        n_checks++; if (rsp_d_q.size() != 0 || str_cnt[2] + str_cnt[3] != 0) begin n_fail++;
            $display("FAIL rm_discard: %0d responses %0d strobes expected 0/0", rsp_d_q.size(), str_cnt[2] + str_cnt[3]); end
        n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %b expected 1", gnt); end
    endtask

    task automatic test_qualification();
        n_checks++; if (qual_viol != 0) begin n_fail++;
            $display("FAIL resp_qualified: %0d cycles with data/err while rvalid=0, expected 0", qual_viol); end
        n_checks++; if (onehot_viol != 0) begin n_fail++;
            $display("FAIL strobe_onehot: %0d multi-hot cycles, expected 0", onehot_viol); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; qual_viol = 0; onehot_viol = 0; to_cnt = 0;
        for (int p = 0; p < NP; p++) begin
            wait_cfg[p] = 0; never[p] = 1'b0; err_cfg[p] = 1'b0; rd_base[p] = '0; wcnt[p] = 0; str_cnt[p] = 0;
        end
        @(negedge clk);
        test_reset();
        test_zero_wait_read();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_overlap_error();
        test_random();
        test_reset_mid();
        test_qualification();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
